// File: rtl/permutation_round_ctrl.sv
// Round sequencer for the permutation datapath: FIRST loads external state, ROUND iterates to ROUND_LAST, DONE pulses.
// Latency N+1 cycles from accepted start to done_o; new requests are accepted only while ready_o is high, never queued.
module permutation_round_ctrl #(
  parameter int ROUND_W    = 4,
  parameter int PA_START   = 0,
  parameter int PB_START   = 6,
  parameter int ROUND_LAST = 11
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               mode_i,
  output logic               ready_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               sel_init_o,
  output logic               en_reg_o,
  output logic               last_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LP_PA_START   = ROUND_W'(PA_START);
  localparam logic [ROUND_W-1:0] LP_PB_START   = ROUND_W'(PB_START);
  localparam logic [ROUND_W-1:0] LP_ROUND_LAST = ROUND_W'(ROUND_LAST);
  localparam logic [ROUND_W-1:0] LP_ONE        = ROUND_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROUND_W-1:0] r_round;
  logic [ROUND_W-1:0] w_round_nxt;
  logic               w_at_last;

  assign w_at_last = (r_round == LP_ROUND_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    ready_o     = 1'b0;
    sel_init_o  = 1'b0;
    en_reg_o    = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        // mode_i is captured only here, so later changes cannot disturb a running permutation
        if (start_i) begin
          w_round_nxt = mode_i ? LP_PB_START : LP_PA_START;
          w_state_nxt = S_FIRST;
        end
      end
      S_FIRST: begin
        en_reg_o    = 1'b1;
        sel_init_o  = 1'b1;
        w_round_nxt = r_round + LP_ONE;
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        en_reg_o = 1'b1;
        if (w_at_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_round_nxt = r_round + LP_ONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign round_o = r_round;
  assign last_o  = ((r_state == S_FIRST) || (r_state == S_ROUND)) && w_at_last;

endmodule

// File: doc/permutation_round_ctrl.md
PERMUTATION_ROUND_CTRL -- requirements
Module: permutation_round_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ROUND_W, 4, width of round index bus.
- PA_START, 0, first round index for p^a (12-round permutation).
- PB_START, 6, first round index for p^b (6-round permutation).
- ROUND_LAST, 11, final round index for both modes.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock_i, in, 1, single clock; all state updates occur on its rising edge.
- reset_i, in, 1, synchronous, active-high reset.
- start_i, in, 1, permutation request, sampled only in IDLE.
- mode_i, in, 1, 0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled with start_i.
- ready_o, out, 1, high when in IDLE and able to accept start_i.
- round_o, out, ROUND_W, round index driving the constant_addition round input.
- sel_init_o, out, 1, state-register input mux select: 1 = external state, 0 = permutation feedback.
- en_reg_o, out, 1, state-register load enable.
- last_o, out, 1, high during the cycle that computes round ROUND_LAST.
- done_o, out, 1, single-cycle pulse when the permutation is complete.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, FIRST, ROUND, DONE, binary-encoded.
REQ-004 In IDLE, the block SHALL drive ready_o=1, en_reg_o=0, sel_init_o=0 and done_o=0.
- round_o holds its last value.
REQ-005 In IDLE, start_i=1 SHALL load the round counter with PB_START if mode_i=1, else PA_START, and SHALL move to FIRST.
REQ-006 In FIRST, the block SHALL drive en_reg_o=1, sel_init_o=1 and ready_o=0, with round_o equal to the loaded start index.
REQ-007 On leaving FIRST, the counter SHALL increment by 1 and the FSM SHALL enter ROUND.
REQ-008 In ROUND, the block SHALL drive en_reg_o=1 and sel_init_o=0.
- If round_o /= ROUND_LAST: increment the counter and stay in ROUND.
- If round_o = ROUND_LAST: hold the counter and go to DONE.
REQ-009 last_o SHALL equal (state in {FIRST, ROUND}) AND (round_o = ROUND_LAST).
REQ-010 In DONE, the block SHALL drive done_o=1, en_reg_o=0 and ready_o=0 for exactly one cycle, then return to IDLE.
REQ-011 Latency: with start_i sampled at edge k, FIRST SHALL occupy cycle k+1.
- en_reg_o is high for exactly N consecutive cycles (N=12 for p^a, N=6 for p^b).
- done_o is high in cycle k+1+N.
REQ-012 start_i and mode_i SHALL be ignored in FIRST, ROUND and DONE; a request is never queued.
REQ-013 start_i=1 in the IDLE cycle immediately after DONE SHALL be accepted, giving back-to-back permutations with one idle cycle between them.
REQ-014 The counter SHALL never exceed ROUND_LAST and SHALL never wrap; round_o SHALL be monotonically increasing during a permutation.
REQ-015 A mode_i change after the start_i acceptance cycle SHALL have no effect on the running permutation.

Reset
REQ-016 When reset_i=1 at a rising edge, the FSM SHALL enter IDLE and the counter SHALL load 0, regardless of state.
- Next cycle outputs: ready_o=1, round_o=0, en_reg_o=0, sel_init_o=0, last_o=0, done_o=0.
REQ-017 Reset asserted mid-permutation SHALL abort it with no done_o pulse.
REQ-018 reset_i SHALL take priority over start_i in the same cycle.

Verification
REQ-019 p^a: reset, then start_i=1, mode_i=0 for one cycle.
- round_o sequence is 0,1,...,11 over 12 cycles with en_reg_o=1.
- sel_init_o=1 only on round 0.
- last_o=1 only on round 11.
- done_o pulses in cycle 13 after the start edge; ready_o returns to 1 in cycle 14.
REQ-020 p^b: start_i=1, mode_i=1.
- round_o sequence is 6,7,...,11 over 6 cycles with en_reg_o=1.
- done_o pulses 7 cycles after the start edge.
REQ-021 Ignored start: hold start_i=1 and toggle mode_i throughout a p^a run.
- Sequence stays 0..11 with exactly one done_o.
- A second run starts the cycle after ready_o rises, with round_o=0 in FIRST.
REQ-022 Reset mid-run: assert reset_i when round_o=5 in p^a.
- Next cycle: IDLE, round_o=0, ready_o=1, en_reg_o=0.
- No done_o pulse occurs.
REQ-023 Reset/start collision: reset_i=1 and start_i=1 in the same cycle.
- Block remains in IDLE with ready_o=1; en_reg_o is never asserted.
REQ-024 Back-to-back: p^b, then start_i=1 in the first IDLE cycle with mode_i=0.
- The two en_reg_o bursts (6 then 12 cycles) are separated by exactly one DONE cycle and one IDLE cycle.
